// File: rtl/lamp_pkg.sv
// Shared types and helpers for the multi-lamp PWM controller.
package lamp_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FLASH_ON  = 2'd1,
        FLASH_OFF = 2'd2,
        STEADY    = 2'd3
    } brake_state_t;

    // Wide all-ones duty; callers slice it down to their PWM width.
    localparam logic [31:0] DUTY_FULL = 32'hFFFF_FFFF;

    // Lamp is lit when the duty is full scale, otherwise while cnt < duty.
    function automatic logic pwm_cmp(input logic [31:0] cnt,
                                     input logic [31:0] duty,
                                     input int unsigned width);
        logic [31:0] full;
        full = 32'hFFFF_FFFF >> (32 - width);
        return (duty == full) || (cnt < duty);
    endfunction

endpackage

// File: rtl/lamp_pwm_channel.sv
// One lamp output: registered compare of the shared PWM counter against a duty.
// With LAMP_FADE_EN defined the duty ramps 1 LSB per counter wrap toward the target.
module lamp_pwm_channel
    import lamp_pkg::*;
#(
    parameter int PWM_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PWM_W-1:0] cnt,
    input  logic [PWM_W-1:0] target,
    input  logic             wrap,
    input  logic             bypass,
    output logic             pwm
);

    logic [PWM_W-1:0] duty;

`ifdef LAMP_FADE_EN
    logic [PWM_W-1:0] duty_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            duty_q <= '0;
        end else if (bypass) begin
            duty_q <= target;
        end else if (wrap) begin
            if (duty_q < target) begin
                duty_q <= duty_q + 1'b1;
            end else if (duty_q > target) begin
                duty_q <= duty_q - 1'b1;
            end
        end
    end

    // Bypassed targets (brake flash/steady) take effect without ramping.
    assign duty = bypass ? target : duty_q;
`else
    logic unused_fade;
    assign unused_fade = wrap ^ bypass;
    assign duty        = target;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm <= 1'b0;
        end else begin
            pwm <= pwm_cmp(32'(cnt), 32'(duty), PWM_W);
        end
    end

endmodule

// File: rtl/lamp_pwm_controller.sv
// Brake/left/right lamp PWM controller: tail dim, turn/hazard blink, brake-onset flash.
// Optional duty ramping is enabled by defining LAMP_FADE_EN.
module lamp_pwm_controller
    import lamp_pkg::*;
#(
    parameter int PWM_W       = 10,
    parameter int PRESCALE    = 48,
    parameter int BLINK_HALF  = 16_500_000,
    parameter int FLASH_HALF  = 2_500_000,
    parameter int FLASH_COUNT = 3
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             brakeActive,
    input  logic             headlightActive,
    input  logic             turnLeft,
    input  logic             turnRight,
    input  logic             hazard,
    input  logic [PWM_W-1:0] dimLevel,
    output logic             brakePWM,
    output logic             leftPWM,
    output logic             rightPWM,
    output logic             brakeFlashing
);

    localparam int PRE_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam int FT_W  = $clog2(FLASH_HALF + 1);
    localparam int BT_W  = $clog2(BLINK_HALF + 1);
    localparam int FC_W  = (FLASH_COUNT > 0) ? $clog2(FLASH_COUNT + 1) : 1;

    logic [PRE_W-1:0] presc;
    logic [PWM_W-1:0] cnt;
    logic             tick;
    logic             wrap;

    assign tick = (presc == PRE_W'(PRESCALE));
    assign wrap = tick && (cnt == '1);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            presc <= '0;
            cnt   <= '0;
        end else if (tick) begin
            presc <= '0;
            cnt   <= cnt + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    brake_state_t    state, state_n;
    logic [FT_W-1:0] timer, timer_n;
    logic [FC_W-1:0] flash_cnt, flash_cnt_n;
    logic            brake_prev;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            flash_cnt  <= '0;
            brake_prev <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            flash_cnt  <= flash_cnt_n;
            brake_prev <= brakeActive;
        end
    end

    always_comb begin
        state_n     = state;
        timer_n     = timer;
        flash_cnt_n = flash_cnt;
        // Releasing the pedal aborts from any state.
        if (!brakeActive) begin
            state_n = IDLE;
            timer_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!brake_prev) begin
                        state_n     = (FLASH_COUNT == 0) ? STEADY : FLASH_ON;
                        timer_n     = '0;
                        flash_cnt_n = '0;
                    end
                end
                FLASH_ON: begin
                    if (timer == FT_W'(FLASH_HALF - 1)) begin
                        state_n = FLASH_OFF;
                        timer_n = '0;
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
                FLASH_OFF: begin
                    if (timer == FT_W'(FLASH_HALF - 1)) begin
                        timer_n     = '0;
                        flash_cnt_n = flash_cnt + 1'b1;
                        state_n     = (flash_cnt_n == FC_W'(FLASH_COUNT)) ? STEADY : FLASH_ON;
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
                STEADY:  state_n = STEADY;
                default: state_n = IDLE;
            endcase
        end
    end

    assign brakeFlashing = (state == FLASH_ON) || (state == FLASH_OFF);

    logic            blink_active;
    logic            phase;
    logic [BT_W-1:0] blink_timer;

    assign blink_active = hazard | turnLeft | turnRight;

    // Idle blinker parks in the ON phase so a fresh request lights at once.
    always_ff @(posedge CLOCK_50) begin
        if (reset || !blink_active) begin
            phase       <= 1'b1;
            blink_timer <= '0;
        end else if (blink_timer == BT_W'(BLINK_HALF - 1)) begin
            phase       <= ~phase;
            blink_timer <= '0;
        end else begin
            blink_timer <= blink_timer + 1'b1;
        end
    end

    logic [PWM_W-1:0] full;
    logic [PWM_W-1:0] base;
    logic             brake_full;
    logic [PWM_W-1:0] brake_target;
    logic [PWM_W-1:0] left_target;
    logic [PWM_W-1:0] right_target;

    assign full         = DUTY_FULL[PWM_W-1:0];
    assign base         = headlightActive ? dimLevel : '0;
    assign brake_full   = (state == FLASH_ON) || (state == STEADY);
    assign brake_target = brake_full ? full : base;
    assign left_target  = ((hazard | turnLeft) && phase) ? full : base;
    assign right_target = ((hazard | turnRight) && phase) ? full : base;

    lamp_pwm_channel #(.PWM_W(PWM_W)) u_brake (
        .clk(CLOCK_50), .reset(reset), .cnt(cnt), .target(brake_target),
        .wrap(wrap), .bypass(brake_full), .pwm(brakePWM)
    );

    lamp_pwm_channel #(.PWM_W(PWM_W)) u_left (
        .clk(CLOCK_50), .reset(reset), .cnt(cnt), .target(left_target),
        .wrap(wrap), .bypass(1'b0), .pwm(leftPWM)
    );

    lamp_pwm_channel #(.PWM_W(PWM_W)) u_right (
        .clk(CLOCK_50), .reset(reset), .cnt(cnt), .target(right_target),
        .wrap(wrap), .bypass(1'b0), .pwm(rightPWM)
    );

endmodule

// File: tb/tb_lamp_pwm_controller.sv
// Scoreboard bench for lamp_pwm_controller: directed scenarios then random segments,
// checked against a time-based reference model of the lamp rules.
`timescale 1ns/1ps
module tb_lamp_pwm_controller;

    localparam int PWM_W       = 4;
    localparam int PRESCALE    = 0;
    localparam int BLINK_HALF  = 8;
    localparam int FLASH_HALF  = 4;
    localparam int FLASH_COUNT = 2;
    localparam int FULL        = (1 << PWM_W) - 1;
    localparam int FLASH_SPAN  = 2 * FLASH_HALF * FLASH_COUNT;

    logic             clk = 1'b0;
    logic             reset;
    logic             brake, headlight, turn_l, turn_r, hz;
    logic [PWM_W-1:0] dim;
    logic             brake_pwm, left_pwm, right_pwm, flashing;

    always #10 clk = ~clk;

    lamp_pwm_controller #(
        .PWM_W(PWM_W), .PRESCALE(PRESCALE), .BLINK_HALF(BLINK_HALF),
        .FLASH_HALF(FLASH_HALF), .FLASH_COUNT(FLASH_COUNT)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .brakeActive(brake),
        .headlightActive(headlight), .turnLeft(turn_l), .turnRight(turn_r),
        .hazard(hz), .dimLevel(dim), .brakePWM(brake_pwm), .leftPWM(left_pwm),
        .rightPWM(right_pwm), .brakeFlashing(flashing)
    );

    logic [3:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: elapsed-time counters since reset, brake onset and blink start.
    int m_cyc;
    int b_age;
    bit b_prev;
    int a_age;
    int fade[3];

    bit s_r, s_b, s_h, s_l, s_rt, s_z;
    int s_d;

    function automatic bit lit(input int cnt, input int duty);
        return (duty == FULL) || (cnt < duty);
    endfunction

`ifdef LAMP_FADE_EN
    function automatic int toward(input int cur, input int tgt);
        return (tgt > cur) ? cur + 1 : (tgt < cur) ? cur - 1 : cur;
    endfunction
`endif

    task automatic model_edge(output logic [3:0] e);
        int  cnt, base, bd, ld, rd;
        bit  on_f, phase_on, bo, lo, ro, fl, is_wrap;
        if (s_r) begin
            m_cyc  = 0;
            b_age  = -1;
            b_prev = 0;
            a_age  = 0;
            fade   = '{0, 0, 0};
            e      = 4'b0000;
        end else begin
            cnt      = (m_cyc / (PRESCALE + 1)) % (FULL + 1);
            is_wrap  = (cnt == FULL) && ((m_cyc % (PRESCALE + 1)) == PRESCALE);
            base     = s_h ? s_d : 0;
            on_f     = (b_age >= 0) && ((b_age >= FLASH_SPAN) || ((b_age / FLASH_HALF) % 2 == 0));
            phase_on = ((a_age / BLINK_HALF) % 2) == 0;
            bd       = on_f ? FULL : base;
            ld       = ((s_z || s_l) && phase_on) ? FULL : base;
            rd       = ((s_z || s_rt) && phase_on) ? FULL : base;
`ifdef LAMP_FADE_EN
            bo = lit(cnt, on_f ? FULL : fade[0]);
            lo = lit(cnt, fade[1]);
            ro = lit(cnt, fade[2]);
            if (on_f) fade[0] = FULL;
            else if (is_wrap) fade[0] = toward(fade[0], bd);
            if (is_wrap) begin
                fade[1] = toward(fade[1], ld);
                fade[2] = toward(fade[2], rd);
            end
`else
            is_wrap = 1'b0;
            bo = lit(cnt, bd);
            lo = lit(cnt, ld);
            ro = lit(cnt, rd);
`endif
            if (!s_b) b_age = -1;
            else if (b_age < 0) begin
                if (!b_prev) b_age = 0;
            end else b_age++;
            b_prev = s_b;
            a_age  = (s_z || s_l || s_rt) ? a_age + 1 : 0;
            m_cyc++;
            fl = (b_age >= 0) && (b_age < FLASH_SPAN);
            e  = {bo, lo, ro, fl};
        end
    endtask

    task automatic run(input int n);
        logic [3:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset     = s_r;
            brake     = s_b;
            headlight = s_h;
            turn_l    = s_l;
            turn_r    = s_rt;
            hz        = s_z;
            dim       = s_d[PWM_W-1:0];
            model_edge(e);
            exp_q.push_back(e);
        end
    endtask

    task automatic set(input bit r, b, h, l, rt, z, input int d);
        s_r = r; s_b = b; s_h = h; s_l = l; s_rt = rt; s_z = z; s_d = d;
    endtask

    // Monitor: every edge is an output sample; pop the matching expectation.
    initial begin
        logic [3:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({brake_pwm, left_pwm, right_pwm, flashing} !== e) begin
                    errors++;
                    $display("FAIL lamps t=%0t got brake/left/right/flash=%b expected=%b",
                             $time, {brake_pwm, left_pwm, right_pwm, flashing}, e);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; brake = 1'b1; headlight = 1'b1;
        turn_l = 1'b1; turn_r = 1'b1; hz = 1'b1; dim = '1;

        set(1, 1, 1, 1, 1, 1, FULL); run(3);
        set(0, 1, 1, 1, 1, 1, FULL); run(20);
        set(0, 0, 1, 0, 0, 0, 4);    run(36);
        set(0, 0, 0, 0, 0, 0, 4);    run(16);
        set(0, 1, 1, 0, 0, 0, 4);    run(24);
        set(0, 0, 1, 0, 0, 0, 4);    run(6);
        set(0, 1, 1, 0, 0, 0, 4);    run(10);
        set(0, 0, 1, 0, 0, 0, 4);    run(8);
        set(0, 0, 1, 1, 0, 0, 3);    run(37);
        set(0, 0, 1, 1, 0, 1, 3);    run(24);
        set(0, 0, 1, 0, 1, 0, 3);    run(20);
        set(0, 0, 1, 1, 0, 0, 3);    run(12);
        set(0, 0, 1, 0, 0, 0, 3);    run(1);
        set(0, 0, 1, 1, 0, 0, 3);    run(4);
        set(0, 0, 1, 0, 0, 0, 0);    run(20);
        set(0, 0, 1, 0, 0, 0, 3);    run(64);

        for (int seg = 0; seg < 300; seg++) begin
            set($urandom_range(0, 39) == 0, $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, FULL));
            run(s_r ? 1 : $urandom_range(1, 28));
        end

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lamp_pwm_controller.md
Name: lamp_pwm_controller

Overview:
- Parametrised multi-lamp PWM controller; next generation of the single-channel brake light dimmer.
- Drives brake, left-turn and right-turn lamps from one shared PWM counter.
- Adds: programmable tail dim level, turn/hazard blinking, and a brake-onset attention flash (N flashes, then steady).
- Sits in SafetySystems between the driver-input debouncers and the lamp MOSFET driver pins.

Parameters:
PWM_W, 10, PWM resolution in bits; duty and counter width
PRESCALE, 48, PWM tick every PRESCALE+1 clocks (50 MHz/49/1024 ≈ 1 kHz PWM)
BLINK_HALF, 16_500_000, clocks per turn-blink half period (≈1.5 Hz)
FLASH_HALF, 2_500_000, clocks per brake-flash half period (10 Hz)
FLASH_COUNT, 3, number of brake flashes before steady-on; 0 disables flashing

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
brakeActive  in  1  brake pedal pressed (pre-synchronised)
headlightActive  in  1  headlights on; enables tail dim level
turnLeft  in  1  left indicator request
turnRight  in  1  right indicator request
hazard  in  1  hazard request
dimLevel  in  PWM_W  tail duty used when headlightActive and lamp otherwise off
brakePWM  out  1  brake lamp drive
leftPWM  out  1  left lamp drive
rightPWM  out  1  right lamp drive
brakeFlashing  out  1  high while brake FSM is in FLASH_ON or FLASH_OFF

Behaviour:
- Interface: single clock CLOCK_50; reset is synchronous and active-high.
- Reset: all outputs 0; PWM counter, prescaler, timers and flash count 0; brake FSM IDLE; blink phase ON; sampled brake 0.
- Prescaler counts 0..PRESCALE. On wrap it issues tick; the PWM counter (PWM_W bits) increments with natural wrap.
- Per lamp duty D: output = (D == all-ones) | (cnt < D). Output is registered, so there is 1 clock latency from a duty change. D = 0 gives constant 0. All-ones gives constant 1.
- Brake FSM:
  - States: IDLE, FLASH_ON, FLASH_OFF, STEADY.
  - IDLE: on brake rising edge (brakeActive & ~prev), go to FLASH_ON, or to STEADY if FLASH_COUNT == 0. Load the timer and clear the flash count.
  - FLASH_ON → FLASH_OFF after FLASH_HALF clocks.
  - FLASH_OFF → FLASH_ON after FLASH_HALF clocks and increment the count. Once the count reaches FLASH_COUNT, go to STEADY instead.
  - Any state: brakeActive low → IDLE on the next clock (mid-flash release aborts).
  - Brake held through reset deassertion counts as a rising edge, because prev resets to 0.
- Brake duty: FLASH_ON/STEADY = all-ones. IDLE/FLASH_OFF = dimLevel if headlightActive, else 0.
- Blink:
  - active = hazard | turnLeft | turnRight.
  - While active, the phase toggles every BLINK_HALF clocks.
  - While inactive, the phase is held ON and the timer is cleared, so a new request lights the lamp immediately.
- Turn duty:
  - hazard, or turnLeft & turnRight: both lamps blink in phase.
  - Single side: that lamp blinks; the other shows base.
  - Blink phase ON = all-ones. Blink phase OFF = base.
  - Base = dimLevel if headlightActive, else 0.
- dimLevel is sampled every clock with no latching.

Optional Feature:
- Macro LAMP_FADE_EN.
- Defined: each lamp holds a duty register that steps 1 LSB per PWM counter wrap toward its target. Brake FLASH_ON and STEADY targets bypass the fade and jump immediately, for safety.
- Undefined: duty equals the target combinationally; no ramp registers are synthesised.

Decomposition:
- Package lamp_pkg:
  - typedef enum brake_state_t {IDLE, FLASH_ON, FLASH_OFF, STEADY}.
  - Function pwm_cmp(cnt, duty).
  - Constant DUTY_FULL.
- Sub-module lamp_pwm_channel (one per lamp): takes the shared cnt, the target duty and the wrap strobe, and produces the registered output. It contains the fade register under LAMP_FADE_EN.

Test Plan:
Bench parameters: PWM_W=4, PRESCALE=0, BLINK_HALF=8, FLASH_HALF=4, FLASH_COUNT=2.
- Reset held with all inputs high → all outputs 0, brakeFlashing 0. Release reset → brakeFlashing 1 on the next clock.
- Brake 0, headlight 1, dimLevel=4 → brakePWM high for exactly 4 of every 16 clocks. headlight 0 → constant 0.
- Brake rising edge → brakePWM pattern 4 on, 4 off (at dim), 4 on, 4 off, then constant 1. brakeFlashing is high for 16 clocks.
- Brake drop during the second FLASH_ON → FSM IDLE next clock, brakeFlashing 0, output returns to dim duty.
- turnLeft pulse → leftPWM 1 for 8 clocks, then base for 8, repeating; rightPWM stays at base. Setting hazard mid-cycle makes both lamps blink in phase.
- Turn request dropped and reasserted during an OFF phase → lamp lit on the first clock after reassertion. With LAMP_FADE_EN, dimLevel 0→3 ramps 1 LSB per 16 clocks.
